// File: rtl/comparador_pkg.sv
// Shared constants and operand-width helper for the comparador block.
package comparador_pkg;

  localparam int SAMPLES_DEF = 2;
  localparam int OSF_DEF     = 8;

  // Operand width: enough bits for SAMPLES*OSF plus one headroom bit.
  function automatic int cmp_width(input int samples, input int osf);
    return $clog2(samples * osf) + 1;
  endfunction

endpackage

// File: rtl/comparador_core.sv
// Purely combinational unsigned compare of two W-bit operands.
module comparador_core #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/comparador.sv
// Registered unsigned greater-than compare with one-cycle latency and valid.
// Optional macro COMPARADOR_EQ_EN adds a registered equality output EqOut.
module comparador
  import comparador_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEF,
  parameter int OSF     = OSF_DEF,
  localparam int W      = cmp_width(SAMPLES, OSF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         InValid,
  input  logic [W-1:0] DataIn1,
  input  logic [W-1:0] DataIn2,
`ifdef COMPARADOR_EQ_EN
  output logic         EqOut,
`endif
  output logic         DataOut,
  output logic         OutValid
);

  logic gt, eq;

  comparador_core #(.W(W)) u_core (
    .a  (DataIn1),
    .b  (DataIn2),
    .gt (gt),
    .eq (eq)
  );

  logic data_out_d, data_out_q;
  logic out_valid_d, out_valid_q;

  // Results only move on a qualified sample; otherwise the last result holds.
  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = InValid;
    if (InValid) data_out_d = gt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign DataOut  = data_out_q;
  assign OutValid = out_valid_q;

`ifdef COMPARADOR_EQ_EN
  logic eq_out_d, eq_out_q;

  always_comb begin
    eq_out_d = eq_out_q;
    if (InValid) eq_out_d = eq;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) eq_out_q <= 1'b0;
    else        eq_out_q <= eq_out_d;
  end

  assign EqOut = eq_out_q;
`else
  logic unused_eq;
  assign unused_eq = eq;
`endif

endmodule

// File: tb/tb_comparador.sv
// Directed self-checking bench for comparador (default SAMPLES/OSF, W=5).
module tb_comparador;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         InValid;
  logic [W-1:0] DataIn1;
  logic [W-1:0] DataIn2;
  logic         DataOut;
  logic         OutValid;
`ifdef COMPARADOR_EQ_EN
  logic         EqOut;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  comparador dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .InValid  (InValid),
    .DataIn1  (DataIn1),
    .DataIn2  (DataIn2),
`ifdef COMPARADOR_EQ_EN
    .EqOut    (EqOut),
`endif
    .DataOut  (DataOut),
    .OutValid (OutValid)
  );

  // Apply inputs away from the edge, then sample #1 after the next rising edge.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rst_n = r; InValid = v; DataIn1 = a; DataIn2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 5'd15, 5'd12);
    drive(1'b0, 1'b1, 5'd15, 5'd12);
    n_checks++;
    if (DataOut !== 1'b0 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: DataOut=%b OutValid=%b, expected 0 0", DataOut, OutValid);
    end
`ifdef COMPARADOR_EQ_EN
    n_checks++;
    if (EqOut !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_eq: EqOut=%b, expected 0", EqOut);
    end
`endif
    // First edge out of reset carries no valid sample.
    drive(1'b1, 1'b0, 5'd15, 5'd12);
    n_checks++;
    if (DataOut !== 1'b0 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: DataOut=%b OutValid=%b, expected 0 0", DataOut, OutValid);
    end
  endtask

  task automatic test_equal_zero();
    drive(1'b1, 1'b1, 5'd0, 5'd0);
    n_checks++;
    if (DataOut !== 1'b0 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL eq_0_0: DataOut=%b OutValid=%b, expected 0 1", DataOut, OutValid);
    end
`ifdef COMPARADOR_EQ_EN
    n_checks++;
    if (EqOut !== 1'b1) begin
      n_fail++;
      $display("FAIL eqout_0_0: EqOut=%b, expected 1", EqOut);
    end
`endif
  endtask

  task automatic test_small();
    drive(1'b1, 1'b1, 5'd1, 5'd0);
    n_checks++;
    if (DataOut !== 1'b1 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL gt_1_0: DataOut=%b OutValid=%b, expected 1 1", DataOut, OutValid);
    end
    drive(1'b1, 1'b1, 5'd0, 5'd1);
    n_checks++;
    if (DataOut !== 1'b0 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL lt_0_1: DataOut=%b OutValid=%b, expected 0 1", DataOut, OutValid);
    end
`ifdef COMPARADOR_EQ_EN
    n_checks++;
    if (EqOut !== 1'b0) begin
      n_fail++;
      $display("FAIL eqout_0_1: EqOut=%b, expected 0", EqOut);
    end
`endif
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 5'd12, 5'd15);
    n_checks++;
    if (DataOut !== 1'b0 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_12_15: DataOut=%b OutValid=%b, expected 0 1", DataOut, OutValid);
    end
    drive(1'b1, 1'b1, 5'd15, 5'd12);
    n_checks++;
    if (DataOut !== 1'b1 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_15_12: DataOut=%b OutValid=%b, expected 1 1", DataOut, OutValid);
    end
    // Upper bit alone decides: 16 vs 15 exercises the full width.
    drive(1'b1, 1'b1, 5'd16, 5'd15);
    n_checks++;
    if (DataOut !== 1'b1 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_16_15: DataOut=%b OutValid=%b, expected 1 1", DataOut, OutValid);
    end
    drive(1'b1, 1'b1, 5'd15, 5'd16);
    n_checks++;
    if (DataOut !== 1'b0 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_15_16: DataOut=%b OutValid=%b, expected 0 1", DataOut, OutValid);
    end
  endtask

  task automatic test_boundary();
    drive(1'b1, 1'b1, 5'd31, 5'd30);
    n_checks++;
    if (DataOut !== 1'b1 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL gt_31_30: DataOut=%b OutValid=%b, expected 1 1", DataOut, OutValid);
    end
    drive(1'b1, 1'b1, 5'd31, 5'd31);
    n_checks++;
    if (DataOut !== 1'b0 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL eq_31_31: DataOut=%b OutValid=%b, expected 0 1", DataOut, OutValid);
    end
`ifdef COMPARADOR_EQ_EN
    n_checks++;
    if (EqOut !== 1'b1) begin
      n_fail++;
      $display("FAIL eqout_31_31: EqOut=%b, expected 1", EqOut);
    end
`endif
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 5'd20, 5'd3);
    n_checks++;
    if (DataOut !== 1'b1 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_setup: DataOut=%b OutValid=%b, expected 1 1", DataOut, OutValid);
    end
    drive(1'b1, 1'b0, 5'd0, 5'd31);
    n_checks++;
    if (DataOut !== 1'b1 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_1: DataOut=%b OutValid=%b, expected 1 0", DataOut, OutValid);
    end
    drive(1'b1, 1'b0, 5'd7, 5'd7);
    n_checks++;
    if (DataOut !== 1'b1 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_1_again: DataOut=%b OutValid=%b, expected 1 0", DataOut, OutValid);
    end
`ifdef COMPARADOR_EQ_EN
    n_checks++;
    if (EqOut !== 1'b0) begin
      n_fail++;
      $display("FAIL eqout_hold: EqOut=%b, expected 0", EqOut);
    end
`endif
    // Holding a 0 result must not drift toward the idle operands.
    drive(1'b1, 1'b1, 5'd2, 5'd9);
    drive(1'b1, 1'b0, 5'd31, 5'd0);
    n_checks++;
    if (DataOut !== 1'b0 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_0: DataOut=%b OutValid=%b, expected 0 0", DataOut, OutValid);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, 5'd25, 5'd4);
    n_checks++;
    if (DataOut !== 1'b1 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: DataOut=%b OutValid=%b, expected 1 1", DataOut, OutValid);
    end
    drive(1'b0, 1'b1, 5'd15, 5'd12);
    n_checks++;
    if (DataOut !== 1'b0 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: DataOut=%b OutValid=%b, expected 0 0", DataOut, OutValid);
    end
    // First valid after release lands one cycle later.
    drive(1'b1, 1'b1, 5'd9, 5'd8);
    n_checks++;
    if (DataOut !== 1'b1 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_after_reset: DataOut=%b OutValid=%b, expected 1 1", DataOut, OutValid);
    end
  endtask

  initial begin
    rst_n = 1'b0; InValid = 1'b0; DataIn1 = '0; DataIn2 = '0;
    test_reset();
    test_equal_zero();
    test_small();
    test_back_to_back();
    test_boundary();
    test_hold();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
